slip_decoder: RTL and testbench

SLIP_DECODER -- requirements
Module: slip_decoder

---
 rtl/slip_decoder_pkg.sv | 23 ++
 rtl/slip_decoder.sv | 199 +++++++++++++++++++
 tb/tb_slip_decoder.sv | 299 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/slip_decoder_pkg.sv
// -----------------------------------------------------------------------------
// slip_pkg
// Shared definitions for the SLIP (RFC 1055) frame decoder:
//   SLIP_END / SLIP_ESC / SLIP_ESC_END / SLIP_ESC_ESC  - protocol byte codes
//   slip_state_t                                       - decoder state type
// -----------------------------------------------------------------------------
package slip_pkg;

    localparam logic [7:0] SLIP_END     = 8'hC0;
    localparam logic [7:0] SLIP_ESC     = 8'hDB;
    localparam logic [7:0] SLIP_ESC_END = 8'hDC;
    localparam logic [7:0] SLIP_ESC_ESC = 8'hDD;

    // NORMAL : in a frame (or between frames), bytes decode literally
    // ESCAPED: previous byte was SLIP_ESC, next byte selects the literal
    // DISCARD: frame was aborted, drop everything up to the next SLIP_END
    typedef enum logic [1:0] {
        ST_NORMAL  = 2'd0,
        ST_ESCAPED = 2'd1,
        ST_DISCARD = 2'd2
    } slip_state_t;

endpackage

// File: rtl/slip_decoder.sv
// -----------------------------------------------------------------------------
// slip_decoder
// Decodes a SLIP-encoded byte stream into framed payload bytes.
//
// One decoded byte is always held back in a pending register so that the
// byte that precedes a SLIP_END (or a protocol error) can be tagged as the
// last beat of its frame. Decoded beats leave through a single registered
// output stage with valid/ready handshaking.
//
// Optional feature: define SLIP_DECODER_LENGTH_CHECK_EN to count decoded
// bytes per frame; the byte after MAX_FRAME_LENGTH aborts the frame as a
// protocol error. Without the macro MAX_FRAME_LENGTH is only range-checked.
//
// Ports:
//   clock       in   rising-edge clock
//   reset       in   synchronous, active-high reset
//   in_valid    in   encoded byte available
//   in_ready    out  encoded byte accepted (combinational)
//   in_data     in   encoded byte [7:0]
//   out_valid   out  decoded byte valid
//   out_ready   in   downstream accepts decoded byte
//   out_data    out  decoded byte [7:0]
//   out_last    out  last byte of the frame
//   out_abort   out  with out_last: frame truncated or corrupt
//   frame_error out  one-cycle pulse per detected protocol error
// -----------------------------------------------------------------------------
module slip_decoder
    import slip_pkg::*;
#(
    parameter int MAX_FRAME_LENGTH = 256
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_data,
    output logic       out_last,
    output logic       out_abort,
    output logic       frame_error
);

    if (MAX_FRAME_LENGTH < 2 || MAX_FRAME_LENGTH > 65535) begin : g_bad_max
        $error("slip_decoder: MAX_FRAME_LENGTH must be in 2..65535");
    end

    // ---------------------------------------------------------------------
    // State
    // ---------------------------------------------------------------------
    slip_state_t r_state;
    logic        r_pend_valid;
    logic [7:0]  r_pend_data;
    logic        r_out_valid;
    logic [7:0]  r_out_data;
    logic        r_out_last;
    logic        r_out_abort;
    logic        r_frame_error;

    // ---------------------------------------------------------------------
    // Byte classification for the currently offered input byte
    // ---------------------------------------------------------------------
    logic        w_accept;
    logic        w_plain;       // a decoded payload byte enters the frame
    logic [7:0]  w_byte;        // its value after un-escaping
    logic        w_end;         // clean end of frame
    logic        w_err;         // protocol error: abort current frame
    logic        w_emit;        // pending byte moves to the output stage
    slip_state_t w_next_state;

`ifdef SLIP_DECODER_LENGTH_CHECK_EN
    localparam int LEN_W = $clog2(MAX_FRAME_LENGTH + 1);
    logic [LEN_W-1:0] r_len;
    logic             w_len_full;
    assign w_len_full = (r_len == LEN_W'(MAX_FRAME_LENGTH));
`endif

    // The output stage is the only buffer after the pending byte, so input
    // may advance exactly when that stage is empty or draining this cycle.
    assign in_ready = !r_out_valid || out_ready;
    assign w_accept = in_valid && in_ready;

    always_comb begin
        w_plain      = 1'b0;
        w_byte       = in_data;
        w_end        = 1'b0;
        w_err        = 1'b0;
        w_next_state = r_state;
        case (r_state)
            ST_NORMAL: begin
                if (in_data == SLIP_END) begin
                    w_end = 1'b1;
                end else if (in_data == SLIP_ESC) begin
                    w_next_state = ST_ESCAPED;
                end else begin
                    w_plain = 1'b1;
                end
            end
            ST_ESCAPED: begin
                w_next_state = ST_NORMAL;
                if (in_data == SLIP_ESC_END) begin
                    w_plain = 1'b1;
                    w_byte  = SLIP_END;
                end else if (in_data == SLIP_ESC_ESC) begin
                    w_plain = 1'b1;
                    w_byte  = SLIP_ESC;
                end else if (in_data == SLIP_END) begin
                    // The END still delimits: next byte opens a fresh frame.
                    w_err = 1'b1;
                end else begin
                    w_err        = 1'b1;
                    w_next_state = ST_DISCARD;
                end
            end
            ST_DISCARD: begin
                if (in_data == SLIP_END) begin
                    w_next_state = ST_NORMAL;
                end
            end
            default: begin
                w_next_state = ST_NORMAL;
            end
        endcase
`ifdef SLIP_DECODER_LENGTH_CHECK_EN
        // An over-length byte is dropped and handled like a bad escape.
        if (w_plain && w_len_full) begin
            w_plain      = 1'b0;
            w_err        = 1'b1;
            w_next_state = ST_DISCARD;
        end
`endif
    end

    assign w_emit = r_pend_valid && (w_plain || w_end || w_err);

    // ---------------------------------------------------------------------
    // Sequential: FSM, pending byte, output stage, error pulse
    // ---------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state       <= ST_NORMAL;
            r_pend_valid  <= 1'b0;
            r_pend_data   <= 8'h00;
            r_out_valid   <= 1'b0;
            r_out_data    <= 8'h00;
            r_out_last    <= 1'b0;
            r_out_abort   <= 1'b0;
            r_frame_error <= 1'b0;
`ifdef SLIP_DECODER_LENGTH_CHECK_EN
            r_len         <= '0;
`endif
        end else begin
            r_frame_error <= 1'b0;

            if (r_out_valid && out_ready) begin
                r_out_valid <= 1'b0;
            end

            if (w_accept) begin
                r_state <= w_next_state;

                // Loading here overrides the drain above when both happen.
                if (w_emit) begin
                    r_out_valid <= 1'b1;
                    r_out_data  <= r_pend_data;
                    r_out_last  <= w_end || w_err;
                    r_out_abort <= w_err;
                end

                if (w_err) begin
                    r_frame_error <= 1'b1;
                end

                if (w_plain) begin
                    r_pend_valid <= 1'b1;
                    r_pend_data  <= w_byte;
                end else if (w_end || w_err) begin
                    r_pend_valid <= 1'b0;
                end

`ifdef SLIP_DECODER_LENGTH_CHECK_EN
                if (w_plain) begin
                    r_len <= r_len + 1'b1;
                end else if (w_end || w_err) begin
                    r_len <= '0;
                end
`endif
            end
        end
    end

    assign out_valid   = r_out_valid;
    assign out_data    = r_out_data;
    assign out_last    = r_out_last;
    assign out_abort   = r_out_abort;
    assign frame_error = r_frame_error;

endmodule

// File: tb/tb_slip_decoder.sv
// -----------------------------------------------------------------------------
// tb_slip_decoder
// Directed protocol scenarios followed by random SLIP streams with random
// downstream back-pressure. Expected beats come from a frame-level model that
// collects each frame's payload and releases it whole on END or error.
// -----------------------------------------------------------------------------
module tb_slip_decoder;
    import slip_pkg::*;

    localparam int MAXL = 4;
`ifdef SLIP_DECODER_LENGTH_CHECK_EN
    localparam bit LIMIT = 1'b1;
`else
    localparam bit LIMIT = 1'b0;
`endif

    typedef logic [7:0] bq_t[$];
    typedef struct packed {
        logic [7:0] d;
        logic       l;
        logic       a;
    } beat_t;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       out_ready = 1'b1;
    logic       in_ready, out_valid, out_last, out_abort, frame_error;
    logic [7:0] out_data;

    always #5 clock = ~clock;

    slip_decoder #(.MAX_FRAME_LENGTH(MAXL)) dut (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last), .out_abort(out_abort), .frame_error(frame_error)
    );

    int    n_cmp = 0;
    int    n_bad = 0;
    int    fe_cnt = 0;
    int    exp_fe = 0;
    bit    hold = 1'b0;
    bit    rnd_rdy = 1'b0;
    beat_t out_q[$];
    beat_t exp_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Downstream ready changes just after the edge so it is stable at negedge.
    always @(posedge clock) begin
        #1;
        out_ready = hold ? 1'b0 : (rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1);
    end

    // Monitor: handshake rules, stability under stall, beat capture.
    beat_t prev_beat;
    bit    prev_stall = 1'b0;
    always @(negedge clock) begin
        if (!reset) begin
            chk("in_ready_rule", in_ready, !out_valid || out_ready);
            if (prev_stall) begin
                chk("stall_valid", out_valid, 1'b1);
                chk("stall_beat", {out_data, out_last, out_abort}, prev_beat);
            end
            if (out_valid) chk("abort_without_last", out_abort && !out_last, 1'b0);
            if (out_valid && out_ready) out_q.push_back('{d: out_data, l: out_last, a: out_abort});
            if (frame_error) fe_cnt++;
            prev_stall = out_valid && !out_ready;
            prev_beat  = '{d: out_data, l: out_last, a: out_abort};
        end else begin
            prev_stall = 1'b0;
        end
    end

    // Reference: gather a frame's payload, release it all at END or error.
    function automatic void release_frame(ref logic [7:0] cur[$], input bit abort);
        for (int k = 0; k < cur.size(); k++)
            exp_q.push_back('{d: cur[k], l: (k == cur.size() - 1), a: abort && (k == cur.size() - 1)});
        cur.delete();
    endfunction

    function automatic void model(input bq_t s);
        logic [7:0] cur[$];
        logic [7:0] b, e;
        int i = 0;
        exp_q.delete();
        exp_fe = 0;
        while (i < s.size()) begin
            b = s[i]; i++;
            if (b == SLIP_END) begin
                release_frame(cur, 1'b0);
                continue;
            end
            if (b == SLIP_ESC) begin
                if (i >= s.size()) break;
                e = s[i]; i++;
                if (e == SLIP_ESC_END) b = SLIP_END;
                else if (e == SLIP_ESC_ESC) b = SLIP_ESC;
                else begin
                    exp_fe++;
                    release_frame(cur, 1'b1);
                    if (e != SLIP_END) begin
                        while (i < s.size() && s[i] != SLIP_END) i++;
                        i++;
                    end
                    continue;
                end
            end
            if (LIMIT && cur.size() == MAXL) begin
                exp_fe++;
                release_frame(cur, 1'b1);
                while (i < s.size() && s[i] != SLIP_END) i++;
                i++;
                continue;
            end
            cur.push_back(b);
        end
    endfunction

    // Drivers: called and returning on a negedge.
    task automatic send(input logic [7:0] b);
        bit acc;
        int t = 0;
        in_valid = 1'b1;
        in_data  = b;
        do begin
            acc = in_ready;
            @(negedge clock);
            t++;
        end while (!acc && t < 500);
        chk("send_accept", acc, 1'b1);
    endtask

    task automatic send_seq(input bq_t s);
        foreach (s[k]) send(s[k]);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        repeat (3) @(negedge clock);
        while (out_valid && t < 300) begin
            @(negedge clock);
            t++;
        end
        chk("drain_idle", out_valid, 1'b0);
        @(negedge clock);
    endtask

    task automatic cmp_beats(input string tag);
        chk({tag, "_count"}, out_q.size(), exp_q.size());
        for (int k = 0; k < out_q.size() && k < exp_q.size(); k++)
            chk({tag, "_beat"}, out_q[k], exp_q[k]);
    endtask

    task automatic start();
        out_q.delete();
        exp_q.delete();
        fe_cnt = 0;
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bq_t s;
        bit  blocked;
        int  r;

        repeat (3) @(negedge clock);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_last", out_last, 1'b0);
        chk("rst_out_abort", out_abort, 1'b0);
        chk("rst_frame_error", frame_error, 1'b0);
        reset = 1'b0;
        @(negedge clock);
        chk("rst_in_ready", in_ready, 1'b1);

        // Simple two-byte frame
        start();
        send_seq('{8'h41, 8'h42, 8'hC0});
        drain();
        exp_q = '{'{8'h41, 1'b0, 1'b0}, '{8'h42, 1'b1, 1'b0}};
        cmp_beats("simple");
        chk("simple_fe", fe_cnt, 0);

        // Empty frames dropped, both escapes decoded
        start();
        send_seq('{8'hC0, 8'hC0, 8'h41, 8'hDB, 8'hDC, 8'hDB, 8'hDD, 8'hC0});
        drain();
        exp_q = '{'{8'h41, 1'b0, 1'b0}, '{8'hC0, 1'b0, 1'b0}, '{8'hDB, 1'b1, 1'b0}};
        cmp_beats("escapes");
        chk("escapes_fe", fe_cnt, 0);

        // Bad escape aborts frame, rest discarded until END
        start();
        send_seq('{8'h41, 8'hDB, 8'h55, 8'h42, 8'hC0, 8'h43, 8'hC0});
        drain();
        exp_q = '{'{8'h41, 1'b1, 1'b1}, '{8'h43, 1'b1, 1'b0}};
        cmp_beats("bad_esc");
        chk("bad_esc_fe", fe_cnt, 1);

        // Downstream stall for 10 cycles
        start();
        hold = 1'b1;
        blocked = 1'b0;
        fork
            send_seq('{8'h01, 8'h02, 8'h03, 8'hC0});
            begin
                repeat (10) begin
                    @(negedge clock);
                    if (!in_ready) blocked = 1'b1;
                end
                hold = 1'b0;
            end
        join
        drain();
        chk("stall_in_ready_low", blocked, 1'b1);
        exp_q = '{'{8'h01, 1'b0, 1'b0}, '{8'h02, 1'b0, 1'b0}, '{8'h03, 1'b1, 1'b0}};
        cmp_beats("stall");

`ifdef SLIP_DECODER_LENGTH_CHECK_EN
        // Over-length frame
        start();
        send_seq('{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'hC0});
        drain();
        exp_q = '{'{8'h01, 1'b0, 1'b0}, '{8'h02, 1'b0, 1'b0}, '{8'h03, 1'b0, 1'b0},
                  '{8'h04, 1'b1, 1'b1}};
        cmp_beats("overlen");
        chk("overlen_fe", fe_cnt, 1);
`endif

        // Reset mid-frame discards pending and held beats
        start();
        hold = 1'b1;
        send_seq('{8'h41, 8'h42});
        repeat (2) @(negedge clock);
        reset = 1'b1;
        repeat (2) @(negedge clock);
        chk("midrst_out_valid", out_valid, 1'b0);
        reset = 1'b0;
        hold = 1'b0;
        @(negedge clock);
        chk("midrst_in_ready", in_ready, 1'b1);
        send_seq('{8'h43, 8'hC0});
        drain();
        exp_q = '{'{8'h43, 1'b1, 1'b0}};
        cmp_beats("midrst");
        chk("midrst_fe", fe_cnt, 0);

        // Random streams with random back-pressure
        rnd_rdy = 1'b1;
        for (int n = 0; n < 25; n++) begin
            s.delete();
            for (int f = 0; f < int'($urandom_range(1, 3)); f++) begin
                for (int k = 0; k < int'($urandom_range(0, 10)); k++) begin
                    r = int'($urandom_range(0, 9));
                    if (r == 0) begin
                        s.push_back(SLIP_ESC);
                        case ($urandom_range(0, 4))
                            0, 1:    s.push_back(SLIP_ESC_END);
                            2:       s.push_back(SLIP_ESC_ESC);
                            3:       s.push_back(8'($urandom_range(0, 255)));
                            default: s.push_back(SLIP_END);
                        endcase
                    end else if (r == 1) begin
                        s.push_back(SLIP_END);
                    end else begin
                        s.push_back(8'($urandom_range(0, 255)));
                    end
                end
                s.push_back(SLIP_END);
            end
            start();
            model(s);
            send_seq(s);
            drain();
            cmp_beats("random");
            chk("random_fe", fe_cnt, exp_fe);
        end
        rnd_rdy = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
